// File: rtl/booth_seq.sv
// Operand/result sequencer for a byte-serial Booth multiplier.
// Optional WAIT timeout abort: define BOOTH_SEQ_TIMEOUT_EN.
module booth_seq #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [7:0]  op_m,
  input  logic [7:0]  op_q,
  output logic        mul_enable,
  output logic [7:0]  mul_inbus,
  input  logic        mul_done,
  input  logic [7:0]  mul_outbus,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_product,
  output logic        res_error
);

  typedef enum logic [2:0] {
    IDLE, LOAD_M, LOAD_Q, WAIT, CAP_HI, CAP_LO, RESULT
  } state_t;

  state_t state, state_nx;

  logic [7:0] m_r, q_r, hi_r, lo_r;
  logic       expired;

`ifdef BOOTH_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          err_r;

  assign expired = (state == WAIT) && !mul_done &&
                   (cnt == CW'(TIMEOUT_CYCLES - 1));

  // cleared while in LOAD_Q so the first WAIT cycle sees zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == LOAD_Q) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (expired) begin
      err_r <= 1'b1;
    end else if (state == RESULT && res_ready) begin
      err_r <= 1'b0;
    end
  end

  assign res_error = err_r;
`else
  assign expired   = 1'b0;
  assign res_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (op_valid) state_nx = LOAD_M;
      LOAD_M:  state_nx = LOAD_Q;
      LOAD_Q:  state_nx = WAIT;
      WAIT: begin
        if (mul_done)     state_nx = CAP_HI;
        else if (expired) state_nx = RESULT;
      end
      CAP_HI:  state_nx = CAP_LO;
      CAP_LO:  state_nx = RESULT;
      RESULT:  if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    op_ready   = 1'b0;
    mul_enable = 1'b0;
    mul_inbus  = 8'h00;
    res_valid  = 1'b0;
    unique case (state)
      IDLE:   op_ready = 1'b1;
      LOAD_M: begin
        mul_enable = 1'b1;
        mul_inbus  = m_r;
      end
      LOAD_Q: mul_inbus = q_r;
      RESULT: res_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r         <= 8'h00;
      q_r         <= 8'h00;
      hi_r        <= 8'h00;
      lo_r        <= 8'h00;
      res_product <= 16'h0000;
    end else begin
      unique case (state)
        IDLE: if (op_valid) begin
          m_r <= op_m;
          q_r <= op_q;
        end
        WAIT: begin
          if (mul_done) hi_r <= mul_outbus;
          else if (expired) res_product <= 16'h0000;
        end
        CAP_HI: lo_r <= mul_outbus;
        CAP_LO: res_product <= {hi_r, lo_r};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq.sv
// Scoreboard bench for booth_seq with a byte-serial multiplier model.
// Timeout path is exercised when BOOTH_SEQ_TIMEOUT_EN is defined.
module tb_booth_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [7:0]  op_m = 8'h00;
  logic [7:0]  op_q = 8'h00;
  logic        mul_enable;
  logic [7:0]  mul_inbus;
  logic        mul_done = 1'b0;
  logic [7:0]  mul_outbus = 8'h00;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_product;
  logic        res_error;

  int checks = 0;
  int errors = 0;
  logic [16:0] sb[$];
  logic [15:0] last_prod = 16'h0000;

  booth_seq #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_m(op_m), .op_q(op_q),
    .mul_enable(mul_enable), .mul_inbus(mul_inbus),
    .mul_done(mul_done), .mul_outbus(mul_outbus),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_product(res_product), .res_error(res_error)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic pop_exp(output logic [16:0] e);
    if (sb.size() == 0) begin
      e = 17'h0;
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic finish_result(input logic [16:0] e, input int hold);
    check("product", res_product, e[15:0]);
    check("error", res_error, e[16]);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", res_valid, 1);
      check("hold_product", res_product, e[15:0]);
      check("hold_ready", op_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    last_prod = e[15:0];
    check("valid_drop", res_valid, 0);
    check("error_clear", res_error, 0);
    check("ready_back", op_ready, 1);
  endtask

  task automatic run_op(input logic [7:0] m, input logic [7:0] q,
                        input int delay, input int hold,
                        input bit spur, input bit keep,
                        input logic [7:0] nm, input logic [7:0] nq);
    byte signed sm, sq;
    logic signed [15:0] p;
    logic [16:0] e;
    int k;
    sm = m;
    sq = q;
    p = sm * sq;
    op_valid = 1'b1;
    op_m = m;
    op_q = q;
    check("ready_idle", op_ready, 1);
    sb.push_back({1'b0, p});
    @(negedge clk);
    if (!keep) begin
      op_valid = 1'b0;
    end else begin
      op_m = nm;
      op_q = nq;
    end
    check("en_load_m", mul_enable, 1);
    check("inbus_m", mul_inbus, m);
    check("ready_busy", op_ready, 0);
    check("prod_held", res_product, last_prod);
    @(negedge clk);
    check("en_load_q", mul_enable, 0);
    check("inbus_q", mul_inbus, q);
    if (spur) begin
      mul_done = 1'b1;
      mul_outbus = 8'hAA;
      @(negedge clk);
      mul_done = 1'b0;
      mul_outbus = 8'h00;
      check("inbus_wait", mul_inbus, 0);
      repeat (delay - 2) @(negedge clk);
    end else begin
      repeat (delay - 1) @(negedge clk);
    end
    check("valid_wait", res_valid, 0);
    mul_done = 1'b1;
    mul_outbus = p[15:8];
    @(negedge clk);
    mul_done = 1'b0;
    mul_outbus = p[7:0];
    k = 1;
    while (!res_valid && k < 10) begin
      @(negedge clk);
      mul_outbus = 8'h00;
      k++;
    end
    check("latency", k, 3);
    pop_exp(e);
    finish_result(e, hold);
  endtask

  initial begin
    #12;
    check("rst_ready", op_ready, 1);
    check("rst_enable", mul_enable, 0);
    check("rst_inbus", mul_inbus, 0);
    check("rst_valid", res_valid, 0);
    check("rst_product", res_product, 0);
    check("rst_error", res_error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // done pulse in IDLE must be ignored
    mul_done = 1'b1;
    mul_outbus = 8'h77;
    @(negedge clk);
    mul_done = 1'b0;
    mul_outbus = 8'h00;
    check("idle_spur_ready", op_ready, 1);
    check("idle_spur_valid", res_valid, 0);
    check("idle_spur_prod", res_product, 0);

    run_op(8'h03, 8'hFE, 9, 5, 1'b0, 1'b0, 8'h00, 8'h00);
    check("first_prod", last_prod, 16'hFFFA);
    run_op(8'h7F, 8'h7F, 4, 0, 1'b1, 1'b0, 8'h00, 8'h00);

    // abandon an operation in WAIT
    op_valid = 1'b1;
    op_m = 8'h05;
    op_q = 8'h07;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_ready", op_ready, 1);
    check("arst_enable", mul_enable, 0);
    check("arst_inbus", mul_inbus, 0);
    check("arst_valid", res_valid, 0);
    check("arst_product", res_product, 0);
    check("arst_error", res_error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_prod = 16'h0000;
    mul_done = 1'b1;
    mul_outbus = 8'h55;
    @(negedge clk);
    mul_done = 1'b0;
    mul_outbus = 8'h00;
    repeat (3) @(negedge clk);
    check("late_done_valid", res_valid, 0);
    check("late_done_ready", op_ready, 1);
    run_op(8'h81, 8'h80, 5, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("reset_prod", last_prod, 16'h3F80);

    // back-to-back with op_valid held high
    run_op(8'hF6, 8'h0C, 3, 0, 1'b0, 1'b1, 8'h80, 8'h01);
    run_op(8'h80, 8'h01, 6, 2, 1'b0, 1'b0, 8'h00, 8'h00);

`ifdef BOOTH_SEQ_TIMEOUT_EN
    begin
      logic [16:0] e;
      int n;
      op_valid = 1'b1;
      op_m = 8'h11;
      op_q = 8'h22;
      sb.push_back({1'b1, 16'h0000});
      @(negedge clk);
      op_valid = 1'b0;
      check("to_en", mul_enable, 1);
      @(negedge clk);
      n = 0;
      while (!res_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("to_cycles", n, 17);
      pop_exp(e);
      finish_result(e, 2);
    end
`endif

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_seq.md
BOOTH_SEQ -- requirements
Module: booth_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, the maximum number of cycles spent in WAIT before abort (used only with BOOTH_SEQ_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  the single clock; all flops update on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port op_valid  input  1  operand pair offered.
REQ-005 SHALL have port op_ready  output  1  sequencer accepts an operand pair this cycle.
REQ-006 SHALL have port op_m  input  8  signed multiplicand.
REQ-007 SHALL have port op_q  input  8  signed multiplier.
REQ-008 SHALL have port mul_enable  output  1  start strobe to the multiplier.
REQ-009 SHALL have port mul_inbus  output  8  operand byte to the multiplier.
REQ-010 SHALL have port mul_done  input  1  multiplier result-phase flag.
REQ-011 SHALL have port mul_outbus  input  8  multiplier result byte.
REQ-012 SHALL have port res_valid  output  1  product available.
REQ-013 SHALL have port res_ready  input  1  consumer accepts the product.
REQ-014 SHALL have port res_product  output  16  signed product {high,low}.
REQ-015 SHALL have port res_error  output  1  the product is invalid because of a timeout (constant 0 when BOOTH_SEQ_TIMEOUT_EN is undefined).

Function
REQ-016 SHALL implement FSM states IDLE, LOAD_M, LOAD_Q, WAIT, CAP_HI, CAP_LO, RESULT.
REQ-017 In IDLE, op_ready SHALL be 1; op_valid=1 SHALL register op_m and op_q and move to LOAD_M.
REQ-018 In every state other than IDLE, op_ready SHALL be 0.
REQ-019 In LOAD_M, mul_enable SHALL be 1 and mul_inbus SHALL be the registered op_m, for exactly one cycle; the FSM SHALL then enter LOAD_Q.
REQ-020 In LOAD_Q, mul_enable SHALL be 0 and mul_inbus SHALL be the registered op_q, for exactly one cycle; the FSM SHALL then enter WAIT.
REQ-021 In all states other than LOAD_M and LOAD_Q, mul_inbus SHALL be 8'h00.
REQ-022 In WAIT, the FSM SHALL stay until it samples mul_done=1, and on that cycle SHALL capture mul_outbus as the high byte and enter CAP_HI.
REQ-023 In CAP_HI, the FSM SHALL capture mul_outbus as the low byte and enter CAP_LO.
REQ-024 CAP_LO SHALL last one cycle; it SHALL assemble res_product = {high,low} and enter RESULT.
REQ-025 In RESULT, res_valid SHALL be 1 and res_product and res_error SHALL be stable until res_ready=1.
REQ-026 On the cycle with res_valid and res_ready both 1, the FSM SHALL return to IDLE; op_ready SHALL rise on the next cycle (no same-cycle accept).
REQ-027 Latency SHALL be: 1 cycle from op accept to LOAD_M, then 2 cycles of load, then N cycles of WAIT, then res_valid 3 cycles after the first mul_done=1 sample.
REQ-028 A mul_done pulse while not in WAIT SHALL be ignored.
REQ-029 op_valid while busy SHALL be ignored, with no buffering.
REQ-030 res_product SHALL hold its last value outside RESULT.

Reset
REQ-031 rst_n=0 SHALL force, asynchronously: state IDLE, op_ready=1 after release, mul_enable=0, mul_inbus=0, res_valid=0, res_product=0, res_error=0, timeout counter=0.
REQ-032 Reset asserted mid-operation SHALL abandon the operation; a mul_done arriving after release SHALL be ignored per REQ-028.

Configuration
REQ-033 With BOOTH_SEQ_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-034 With BOOTH_SEQ_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES without mul_done, the FSM SHALL enter RESULT with res_product=16'h0000 and res_error=1.
REQ-035 With BOOTH_SEQ_TIMEOUT_EN defined, res_error SHALL clear on the RESULT handshake.
REQ-036 Without BOOTH_SEQ_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL be unbounded, and res_error SHALL be tied to 0.

Verification
REQ-037 Bench SHALL apply op_m=3, op_q=-2 with a model asserting done after 9 cycles, outbus=8'hFF then 8'hFA -> mul_enable for 1 cycle with inbus 03, next cycle inbus FE; res_product=16'hFFFA.
REQ-038 Bench SHALL hold res_ready=0 for 5 cycles in RESULT -> res_valid stays 1, product stable, op_ready stays 0.
REQ-039 Bench SHALL pulse mul_done during IDLE and LOAD_Q -> no capture, and no state change beyond normal flow.
REQ-040 Bench SHALL drop rst_n during WAIT -> outputs reset immediately; a later op -127 x -128 completes with 16'h3F80.
REQ-041 With BOOTH_SEQ_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, bench SHALL never assert done -> res_valid after 16 WAIT cycles, res_error=1, product 0.
REQ-042 Bench SHALL run back-to-back ops with op_valid held high -> the second op is accepted exactly 1 cycle after the first result handshake.
